// File: rtl/rca32_seq_add.sv
// ---------------------------------------------------------------------------
// rca32_seq_add -- sequential WIDTH-bit adder built around one 4-bit
// ripple-carry slice that is reused once per clock cycle.
//
// A request accepted in IDLE is processed four bits per cycle, starting at
// the least significant nibble. The result is presented in DONE and held
// until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request valid (looked at only in IDLE)
//   in_ready   high only in IDLE
//   a, b, cin  addends and carry-in, captured on the accept edge
//   flush      synchronous abort; wins over every other action
//   out_valid  result valid, high only in DONE
//   out_ready  consumer accepts the result
//   sum        low WIDTH bits of a+b+cin
//   cout       carry out of bit WIDTH-1
//   ovf        two's-complement overflow of the signed addition
//   busy       high in RUN or DONE
//
// WIDTH must be a multiple of 4 and at least 8.
// ---------------------------------------------------------------------------

// 4-bit ripple-carry adder slice: the only adder in the datapath.
module rca_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic c1_s;
  logic c2_s;
  logic c3_s;

  // Full-adder chain; each stage carries into the next.
  assign sum[0] = a[0] ^ b[0] ^ cin;
  assign c1_s   = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
  assign sum[1] = a[1] ^ b[1] ^ c1_s;
  assign c2_s   = (a[1] & b[1]) | (c1_s & (a[1] ^ b[1]));
  assign sum[2] = a[2] ^ b[2] ^ c2_s;
  assign c3_s   = (a[2] & b[2]) | (c2_s & (a[2] ^ b[2]));
  assign sum[3] = a[3] ^ b[3] ^ c3_s;
  assign cout   = (a[3] & b[3]) | (c3_s & (a[3] ^ b[3]));

endmodule

module rca32_seq_add #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               ovf_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;

  logic [IDX_W+1:0]   bit_base_s;
  logic [3:0]         slice_a_s;
  logic [3:0]         slice_b_s;
  logic [3:0]         slice_sum_s;
  logic               slice_cout_s;
  logic               last_slice_s;
  logic               final_ovf_s;

  // Select the nibble addressed by the slice index from the latched operands.
  always_comb begin
    bit_base_s   = {idx_r, 2'b00};
    slice_a_s    = a_r[bit_base_s +: 4];
    slice_b_s    = b_r[bit_base_s +: 4];
    last_slice_s = (idx_r == LAST_IDX);
    // The top slice produces sum[MSB], so overflow is decided on that cycle.
    if (last_slice_s) begin
      final_ovf_s = signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], slice_sum_s[3]);
    end else begin
      final_ovf_s = 1'b0;
    end
  end

  rca_4 u_slice (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Control FSM together with the operand, sum and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      carry_r     <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (flush) begin
      // Abort overrides accept, slice update and result handshake.
      state_r     <= ST_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      carry_r     <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            carry_r    <= cin;
            idx_r      <= {IDX_W{1'b0}};
            sum_r      <= {WIDTH{1'b0}};
            state_r    <= ST_RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        ST_RUN: begin
          sum_r[bit_base_s +: 4] <= slice_sum_s;
          carry_r                <= slice_cout_s;
          if (last_slice_s) begin
            // Index returns to zero so a non-power-of-two N never overruns.
            idx_r       <= {IDX_W{1'b0}};
            cout_r      <= slice_cout_s;
            ovf_r       <= final_ovf_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        ST_DONE: begin
          // Result held until taken; no new accept on the handshake edge.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          idx_r       <= {IDX_W{1'b0}};
          carry_r     <= 1'b0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule
